// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I instruction packer with a valid/ready stream on both sides.
// Defining IMM_ENC_CHECK_EN enables immediate range/alignment checking and request rejection.

`ifndef I_type
`define I_type 3'd0
`endif
`ifndef I_type_load
`define I_type_load 3'd1
`endif
`ifndef S_type
`define S_type 3'd2
`endif
`ifndef B_type
`define B_type 3'd3
`endif
`ifndef J_type
`define J_type 3'd4
`endif
`ifndef U_type_LUI
`define U_type_LUI 3'd5
`endif
`ifndef U_type_AUIPC
`define U_type_AUIPC 3'd6
`endif

module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [2:0]  out_fmt,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);

    function automatic logic [31:0] pack_word(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [2:0]  funct3,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        logic [31:0] word;
        word = 32'h0000_0000;
        case (fmt)
            `I_type, `I_type_load:      word = {imm[11:0], rs1, funct3, rd, opcode};
            `S_type:                    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            `B_type:                    word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            `J_type:                    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            `U_type_LUI, `U_type_AUIPC: word = {imm[31:12], rd, opcode};
            default:                    word = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
        return word;
    endfunction

`ifdef IMM_ENC_CHECK_EN
    // Returns 01 range, 10 misaligned, 11 U low bits set; range wins over alignment.
    function automatic logic [1:0] imm_check(input logic [2:0] fmt, input logic [31:0] imm);
        logic [1:0] code;
        code = 2'b00;
        case (fmt)
            `I_type, `I_type_load, `S_type: begin
                if (imm[31:11] != {21{imm[31]}}) code = 2'b01;
                else                             code = 2'b00;
            end
            `B_type: begin
                // 4095 fits the 13-bit signed span but lies above the 4094 limit
                if ((imm[31:12] != {20{imm[31]}}) || (imm == 32'h0000_0FFF)) code = 2'b01;
                else if (imm[0])                                             code = 2'b10;
                else                                                         code = 2'b00;
            end
            `J_type: begin
                if ((imm[31:20] != {12{imm[31]}}) || (imm == 32'h000F_FFFF)) code = 2'b01;
                else if (imm[0])                                             code = 2'b10;
                else                                                         code = 2'b00;
            end
            `U_type_LUI, `U_type_AUIPC: begin
                if (imm[11:0] != 12'h000) code = 2'b11;
                else                      code = 2'b00;
            end
            default: code = 2'b00;
        endcase
        return code;
    endfunction
`endif

    logic        s1_valid_r;
    logic [31:0] s1_instr_r;
    logic [2:0]  s1_fmt_r;
    logic [1:0]  s1_code_r;
    logic        s1_rej_s;
    logic        s1_adv_s;
    logic        in_ready_s;
    logic        in_fire_s;
    logic [1:0]  in_code_s;
    logic        out_valid_r;
    logic [31:0] out_instr_r;
    logic [2:0]  out_fmt_r;
    logic        err_valid_r;
    logic [1:0]  err_code_r;
    logic [15:0] enc_count_r;
    logic [15:0] err_count_r;

    // Stage-1 advance and input acceptance; a rejected entry never waits on S2.
    always_comb begin
        in_code_s  = 2'b00;
`ifdef IMM_ENC_CHECK_EN
        in_code_s  = imm_check(in_fmt, in_imm);
`endif
        s1_rej_s   = s1_valid_r & (s1_code_r != 2'b00);
        s1_adv_s   = s1_valid_r & (s1_rej_s | ~out_valid_r | out_ready);
        in_ready_s = ~s1_valid_r | s1_adv_s;
        in_fire_s  = in_valid & in_ready_s;
    end

    // Stage 1: holds the packed word and its check result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_instr_r <= 32'h0000_0000;
            s1_fmt_r   <= 3'd0;
            s1_code_r  <= 2'b00;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_instr_r <= pack_word(in_fmt, in_opcode, in_rd, in_funct3,
                                    in_rs1, in_rs2, in_funct7, in_imm);
            s1_fmt_r   <= in_fmt;
            s1_code_r  <= in_code_s;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: output word register, error reporting and event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_fmt_r   <= 3'd0;
            err_valid_r <= 1'b0;
            err_code_r  <= 2'b00;
            enc_count_r <= 16'h0000;
            err_count_r <= 16'h0000;
        end else begin
            if (s1_adv_s & ~s1_rej_s) begin
                out_valid_r <= 1'b1;
                out_instr_r <= s1_instr_r;
                out_fmt_r   <= s1_fmt_r;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            err_valid_r <= s1_adv_s & s1_rej_s;
            if (s1_adv_s & s1_rej_s) begin
                err_code_r  <= s1_code_r;
                err_count_r <= err_count_r + 16'h0001;
            end
            if (out_valid_r & out_ready) begin
                enc_count_r <= enc_count_r + 16'h0001;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_instr = out_instr_r;
    assign out_fmt   = out_fmt_r;
    assign err_valid = err_valid_r;
    assign err_code  = err_code_r;
    assign enc_count = enc_count_r;
    assign err_count = err_count_r;

endmodule
